// File: rtl/pc8001_ps2_keymatrix.sv
// pc8001_ps2_keymatrix
//   Turns hps_io PS/2 key events into the PC-8001 10x8 active-low keyboard
//   matrix that the core samples through its I/O ports 00h-09h.
//   Events pass through a 3-stage pipeline (detect -> decode -> apply), so a
//   new event can be accepted every cycle.
// Ports:
//   clk_sys    system clock; ps2_key and kbd_row are synchronous to it
//   reset_n    asynchronous active-low reset
//   ps2_key    [10] toggle strobe, [9] make, [8] E0-extended, [7:0] scancode
//   kbd_flush  level; releases every key while high
//   kbd_row    matrix row selected by the core
//   kbd_data   column byte of the selected row, 0 = pressed (1-cycle latency)
//   any_key    1 while any matrix bit (including Shift) is pressed
//   evt_valid  one-cycle pulse when a mapped event reaches the matrix
module pc8001_ps2_keymatrix #(
  parameter int unsigned NUM_ROWS    = 10,
  parameter int unsigned KEY_TIMEOUT = 0,
  parameter int unsigned TO_W        = 32
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        kbd_flush,
  input  logic [3:0]  kbd_row,
  output logic [7:0]  kbd_data,
  output logic        any_key,
  output logic        evt_valid
);

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned DEC_W  = 1 + ROW_W + COL_W;
  localparam int unsigned SHIFT_ROW = 8;
  localparam int unsigned SHIFT_COL = 6;

  // Packs a ROM entry as {hit, row, col}.
  function automatic logic [DEC_W-1:0] rc(input int unsigned r, input int unsigned c);
    return {1'b1, ROW_W'(r), COL_W'(c)};
  endfunction

  logic                strobe_q;
  logic                s1_valid;
  logic                s1_pressed;
  logic                s1_ext;
  logic [CODE_W-1:0]   s1_code;
  logic                s2_hit;
  logic                s2_shl;
  logic                s2_shr;
  logic                s2_pressed;
  logic [ROW_W-1:0]    s2_row;
  logic [COL_W-1:0]    s2_col;
  logic [7:0]          matrix [NUM_ROWS];
  logic                shift_l;
  logic                shift_r;
  logic [TO_W-1:0]     to_cnt;

  logic                new_evt_c;
  logic [DEC_W-1:0]    dec_c;
  logic                dec_shl_c;
  logic                dec_shr_c;
  logic                dec_row_ok_c;
  logic                to_flush_c;
  logic                flush_c;
  logic [7:0]          rd_c;
  logic                any_c;

  // Strobe edge marks a new event; any toggle counts, mapped or not.
  always_comb new_evt_c = ps2_key[10] ^ strobe_q;

  // Internal timeout flush is a single-cycle pulse merged with kbd_flush.
  always_comb begin
    to_flush_c = 1'b0;
    if (KEY_TIMEOUT != 0) to_flush_c = (to_cnt == TO_W'(KEY_TIMEOUT));
    flush_c = kbd_flush | to_flush_c;
  end

  // Scancode ROM: {ext, code} -> {hit, row, col}. Shift keys bypass the matrix.
  always_comb begin
    dec_c     = '0;
    dec_shl_c = 1'b0;
    dec_shr_c = 1'b0;
    case ({s1_ext, s1_code})
      // row 0: keypad 0-7
      9'h070: dec_c = rc(0, 0);
      9'h069: dec_c = rc(0, 1);
      9'h072: dec_c = rc(0, 2);
      9'h07A: dec_c = rc(0, 3);
      9'h06B: dec_c = rc(0, 4);
      9'h073: dec_c = rc(0, 5);
      9'h074: dec_c = rc(0, 6);
      9'h06C: dec_c = rc(0, 7);
      // row 1: keypad 8 9 * + . and RETURN (main and keypad Enter)
      9'h075: dec_c = rc(1, 0);
      9'h07D: dec_c = rc(1, 1);
      9'h07C: dec_c = rc(1, 2);
      9'h079: dec_c = rc(1, 3);
      9'h071: dec_c = rc(1, 6);
      9'h05A: dec_c = rc(1, 7);
      9'h15A: dec_c = rc(1, 7);
      // row 2: @ A-G
      9'h054: dec_c = rc(2, 0);
      9'h01C: dec_c = rc(2, 1);
      9'h032: dec_c = rc(2, 2);
      9'h021: dec_c = rc(2, 3);
      9'h023: dec_c = rc(2, 4);
      9'h024: dec_c = rc(2, 5);
      9'h02B: dec_c = rc(2, 6);
      9'h034: dec_c = rc(2, 7);
      // row 3: H-O
      9'h033: dec_c = rc(3, 0);
      9'h043: dec_c = rc(3, 1);
      9'h03B: dec_c = rc(3, 2);
      9'h042: dec_c = rc(3, 3);
      9'h04B: dec_c = rc(3, 4);
      9'h03A: dec_c = rc(3, 5);
      9'h031: dec_c = rc(3, 6);
      9'h044: dec_c = rc(3, 7);
      // row 4: P-W
      9'h04D: dec_c = rc(4, 0);
      9'h015: dec_c = rc(4, 1);
      9'h02D: dec_c = rc(4, 2);
      9'h01B: dec_c = rc(4, 3);
      9'h02C: dec_c = rc(4, 4);
      9'h03C: dec_c = rc(4, 5);
      9'h02A: dec_c = rc(4, 6);
      9'h01D: dec_c = rc(4, 7);
      // row 5: X Y Z [ \ ] ^ -
      9'h022: dec_c = rc(5, 0);
      9'h035: dec_c = rc(5, 1);
      9'h01A: dec_c = rc(5, 2);
      9'h05B: dec_c = rc(5, 3);
      9'h06A: dec_c = rc(5, 4);
      9'h05D: dec_c = rc(5, 5);
      9'h055: dec_c = rc(5, 6);
      9'h04E: dec_c = rc(5, 7);
      // row 6: 0-7
      9'h045: dec_c = rc(6, 0);
      9'h016: dec_c = rc(6, 1);
      9'h01E: dec_c = rc(6, 2);
      9'h026: dec_c = rc(6, 3);
      9'h025: dec_c = rc(6, 4);
      9'h02E: dec_c = rc(6, 5);
      9'h036: dec_c = rc(6, 6);
      9'h03D: dec_c = rc(6, 7);
      // row 7: 8 9 : ; , . / _
      9'h03E: dec_c = rc(7, 0);
      9'h046: dec_c = rc(7, 1);
      9'h052: dec_c = rc(7, 2);
      9'h04C: dec_c = rc(7, 3);
      9'h041: dec_c = rc(7, 4);
      9'h049: dec_c = rc(7, 5);
      9'h04A: dec_c = rc(7, 6);
      9'h051: dec_c = rc(7, 7);
      // row 8: HOME UP RIGHT DEL GRPH KANA (SHIFT) CTRL
      9'h16C: dec_c = rc(8, 0);
      9'h175: dec_c = rc(8, 1);
      9'h174: dec_c = rc(8, 2);
      9'h066: dec_c = rc(8, 3);
      9'h171: dec_c = rc(8, 3);
      9'h011: dec_c = rc(8, 4);
      9'h111: dec_c = rc(8, 5);
      9'h014: dec_c = rc(8, 7);
      9'h114: dec_c = rc(8, 7);
      9'h012: dec_shl_c = 1'b1;
      9'h059: dec_shr_c = 1'b1;
      // row 9: STOP F1-F5 SPACE ESC
      9'h009: dec_c = rc(9, 0);
      9'h005: dec_c = rc(9, 1);
      9'h006: dec_c = rc(9, 2);
      9'h004: dec_c = rc(9, 3);
      9'h00C: dec_c = rc(9, 4);
      9'h003: dec_c = rc(9, 5);
      9'h029: dec_c = rc(9, 6);
      9'h076: dec_c = rc(9, 7);
      default: ;
    endcase
    // Rows beyond NUM_ROWS are not stored, so such hits are dropped.
    dec_row_ok_c = (32'(dec_c[COL_W +: ROW_W]) < NUM_ROWS);
  end

  // Row read mux; Shift is overlaid onto r8b6 instead of being stored.
  always_comb begin
    rd_c = 8'hFF;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (kbd_row == ROW_W'(r)) rd_c = matrix[r];
    end
    if ((NUM_ROWS > SHIFT_ROW) && (kbd_row == ROW_W'(SHIFT_ROW)))
      rd_c[SHIFT_COL] = ~(shift_l | shift_r);
  end

  always_comb begin
    any_c = shift_l | shift_r;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (matrix[r] != 8'hFF) any_c = 1'b1;
    end
  end

  // Event pipeline: detect/capture (stage 1) then decode (stage 2).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_pressed <= 1'b0;
      s1_ext     <= 1'b0;
      s1_code    <= '0;
      s2_hit     <= 1'b0;
      s2_shl     <= 1'b0;
      s2_shr     <= 1'b0;
      s2_pressed <= 1'b0;
      s2_row     <= '0;
      s2_col     <= '0;
    end else begin
      strobe_q   <= ps2_key[10];
      s1_valid   <= new_evt_c & ~flush_c;
      s1_pressed <= ps2_key[9];
      s1_ext     <= ps2_key[8];
      s1_code    <= ps2_key[7:0];
      s2_hit     <= s1_valid & dec_c[DEC_W-1] & dec_row_ok_c & ~flush_c;
      s2_shl     <= s1_valid & dec_shl_c & ~flush_c;
      s2_shr     <= s1_valid & dec_shr_c & ~flush_c;
      s2_pressed <= s1_pressed;
      s2_row     <= dec_c[COL_W +: ROW_W];
      s2_col     <= dec_c[COL_W-1:0];
    end
  end

  // Apply stage: matrix/shift update; flush overrides any staged event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 8'hFF;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      evt_valid <= 1'b0;
    end else if (flush_c) begin
      for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 8'hFF;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      evt_valid <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (s2_hit && (s2_row == ROW_W'(r))) matrix[r][s2_col] <= ~s2_pressed;
      end
      if (s2_shl) shift_l <= s2_pressed;
      if (s2_shr) shift_r <= s2_pressed;
      evt_valid <= s2_hit | s2_shl | s2_shr;
    end
  end

  // Registered read data and any-key flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      kbd_data <= 8'hFF;
      any_key  <= 1'b0;
    end else begin
      kbd_data <= rd_c;
      any_key  <= any_c;
    end
  end

  // Stuck-key timeout counter; saturates rather than wrapping.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if ((KEY_TIMEOUT == 0) || flush_c || new_evt_c || !any_key) begin
      to_cnt <= '0;
    end else if (to_cnt != '1) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_pc8001_ps2_keymatrix.sv
// Testbench for pc8001_ps2_keymatrix: default instance plus a KEY_TIMEOUT=16
// instance. Mapped events push their expected evt_valid cycle into a queue;
// a negedge monitor pops and compares whenever evt_valid is seen.
module tb_pc8001_ps2_keymatrix;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        kbd_flush;
  logic [3:0]  kbd_row;
  logic [7:0]  kbd_data;
  logic        any_key;
  logic        evt_valid;

  logic [10:0] ps2_key_t;
  logic        kbd_flush_t;
  logic [3:0]  kbd_row_t;
  logic [7:0]  kbd_data_t;
  logic        any_key_t;
  logic        evt_valid_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];
  int exp_cyc;
  int waited;

  pc8001_ps2_keymatrix dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .kbd_flush (kbd_flush),
    .kbd_row   (kbd_row),
    .kbd_data  (kbd_data),
    .any_key   (any_key),
    .evt_valid (evt_valid)
  );

  pc8001_ps2_keymatrix #(.KEY_TIMEOUT(16)) dut_to (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key_t),
    .kbd_flush (kbd_flush_t),
    .kbd_row   (kbd_row_t),
    .kbd_data  (kbd_data_t),
    .any_key   (any_key_t),
    .evt_valid (evt_valid_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Toggle the strobe at a negedge; mapped events expect evt_valid 3 negedges later.
  task automatic send(input bit make, input bit ext, input logic [7:0] code, input bit mapped);
    @(negedge clk);
    ps2_key = {~ps2_key[10], make, ext, code};
    if (mapped) exp_q.push_back(cyc + 3);
  endtask

  task automatic send_t(input bit make, input bit ext, input logic [7:0] code);
    @(negedge clk);
    ps2_key_t = {~ps2_key_t[10], make, ext, code};
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every evt_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && evt_valid) begin
      if (exp_q.size() == 0) begin
        check("evt_spurious", 32'(evt_valid), 32'd0);
      end else begin
        exp_cyc = exp_q.pop_front();
        check("evt_latency", cyc, exp_cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    ps2_key     = '0;
    kbd_flush   = 1'b0;
    kbd_row     = 4'd2;
    ps2_key_t   = '0;
    kbd_flush_t = 1'b0;
    kbd_row_t   = 4'd2;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(2);
    check("rst_data", kbd_data, 8'hFF);
    check("rst_any", any_key, 1'b0);
    check("rst_evt", evt_valid, 1'b0);

    // A make: data changes exactly 4 negedges after the strobe is driven.
    send(1, 0, 8'h1C, 1);
    wait_n(3);
    check("a_make_early", kbd_data, 8'hFF);
    wait_n(1);
    check("a_make", kbd_data, 8'hFD);
    check("a_any", any_key, 1'b1);
    send(1'b0, 0, 8'h1C, 1);
    wait_n(4);
    check("a_break", kbd_data, 8'hFF);
    check("a_break_any", any_key, 1'b0);

    // Shift overlap on r8b6.
    kbd_row = 4'd8;
    send(1, 0, 8'h12, 1); wait_n(4); check("shl_make", kbd_data, 8'hBF);
    send(1, 0, 8'h59, 1); wait_n(4); check("shr_make", kbd_data, 8'hBF);
    send(0, 0, 8'h12, 1); wait_n(4); check("shl_break", kbd_data, 8'hBF);
    check("shr_any", any_key, 1'b1);
    send(0, 0, 8'h59, 1); wait_n(4); check("shr_break", kbd_data, 8'hFF);

    // Extended vs. non-extended 75, and Enter via E0 5A.
    send(1, 1, 8'h75, 1); wait_n(4); check("up_make", kbd_data, 8'hFD);
    send(1, 0, 8'h75, 1); wait_n(4); check("kp8_row8", kbd_data, 8'hFD);
    kbd_row = 4'd1; wait_n(1); check("kp8_row1", kbd_data, 8'hFE);
    send(1, 1, 8'h5A, 1); wait_n(4); check("kpenter", kbd_data, 8'h7E);
    send(0, 1, 8'h75, 1);
    send(0, 0, 8'h75, 1);
    send(0, 1, 8'h5A, 1);
    wait_n(4);
    check("row1_clear", kbd_data, 8'hFF);
    check("ext_any", any_key, 1'b0);

    // Back-to-back: three mapped events on consecutive cycles, then an unmapped one.
    kbd_row = 4'd9;
    send(1, 0, 8'h29, 1);
    send(1, 0, 8'h76, 1);
    send(1, 0, 8'h05, 1);
    send(1, 0, 8'h7E, 0);
    wait_n(5);
    check("b2b_row9", kbd_data, 8'h3D);
    send(0, 0, 8'h29, 1);
    send(0, 0, 8'h76, 1);
    send(0, 0, 8'h05, 1);
    wait_n(4);
    check("b2b_clear", kbd_data, 8'hFF);

    // Out-of-range rows read FF while a key is held.
    kbd_row = 4'd2;
    send(1, 0, 8'h1C, 1); wait_n(4); check("hold_a", kbd_data, 8'hFD);
    kbd_row = 4'd10; wait_n(1); check("row10", kbd_data, 8'hFF);
    kbd_row = 4'd15; wait_n(1); check("row15", kbd_data, 8'hFF);
    kbd_row = 4'd2;  wait_n(1); check("row2_back", kbd_data, 8'hFD);

    // One-cycle flush releases the held key.
    kbd_flush = 1'b1; wait_n(1);
    kbd_flush = 1'b0; wait_n(1);
    check("flush_data", kbd_data, 8'hFF);
    check("flush_any", any_key, 1'b0);

    // Flush one cycle after the strobe discards the in-flight event.
    send(1, 0, 8'h1C, 0);
    @(negedge clk); kbd_flush = 1'b1;
    @(negedge clk); kbd_flush = 1'b0;
    wait_n(4);
    check("inflight_data", kbd_data, 8'hFF);
    check("inflight_any", any_key, 1'b0);

    // Timeout instance: A held with no further events is force-released.
    send_t(1, 0, 8'h1C);
    wait_n(4);
    check("to_make", kbd_data_t, 8'hFD);
    check("to_any", any_key_t, 1'b1);
    wait_n(8);
    check("to_hold", any_key_t, 1'b1);
    waited = 12;
    for (int i = 0; i < 40 && any_key_t; i++) begin
      @(negedge clk);
      waited++;
    end
    check("to_release", any_key_t, 1'b0);
    check("to_min_wait", 32'(waited >= 16), 32'd1);
    check("to_data", kbd_data_t, 8'hFF);

    wait_n(4);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
